// File: rtl/axil_wresp_gen_if.sv
// Bundles the backend write-done strobe and the AXI-Lite B channel for axil_wresp_gen.
// slave: the response generator; master: the backend/bus side that drives it.
interface axil_wresp_gen_if;
  logic       WR_DONE;
  logic       WR_SLVERR;
  logic       WR_DECERR;
  logic       WR_FULL;
  logic       WR_OVF;
  logic       AXI_BVALID;
  logic [1:0] AXI_BRESP;
  logic       AXI_BREADY;
  logic       BREADY_TIMEOUT;

  modport slave (
    input  WR_DONE,
    input  WR_SLVERR,
    input  WR_DECERR,
    input  AXI_BREADY,
    output WR_FULL,
    output WR_OVF,
    output AXI_BVALID,
    output AXI_BRESP,
    output BREADY_TIMEOUT
  );

  modport master (
    output WR_DONE,
    output WR_SLVERR,
    output WR_DECERR,
    output AXI_BREADY,
    input  WR_FULL,
    input  WR_OVF,
    input  AXI_BVALID,
    input  AXI_BRESP,
    input  BREADY_TIMEOUT
  );
endinterface

// File: rtl/axil_wresp_gen.sv
// AXI-Lite write-response generator: queues backend write results and replays them on B in order.
// Optional BREADY watchdog enabled by defining AXIL_WRESP_BREADY_TIMEOUT_EN.
module axil_wresp_gen #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned MAXWAIT = 5
) (
  input  logic               AXI_ACLK,
  input  logic               AXI_ARESET,
  axil_wresp_gen_if.slave    bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || MAXWAIT == 0) begin : g_param_check
    $error("axil_wresp_gen: DEPTH must be a power of 2 >= 2 and MAXWAIT nonzero");
  end

  logic [1:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_bvalid;
  logic [1:0]    r_bresp;
  logic          r_full;
  logic          r_ovf;

  logic          w_push;
  logic          w_pop;
  logic [1:0]    w_resp_enc;
  logic [AW-1:0] w_rd_ptr_next;
  logic [CW-1:0] w_count_next;
  logic [1:0]    w_bresp_next;

  always_comb begin
    w_resp_enc = 2'b00;
    if (bus.WR_DECERR) begin
      w_resp_enc = 2'b11;
    end else if (bus.WR_SLVERR) begin
      w_resp_enc = 2'b10;
    end

    w_push        = bus.WR_DONE & ~r_full;
    w_pop         = r_bvalid & bus.AXI_BREADY;
    w_rd_ptr_next = r_rd_ptr + AW'(w_pop);

    w_count_next = r_count;
    if (w_push && !w_pop) begin
      w_count_next = r_count + CW'(1);
    end else if (w_pop && !w_push) begin
      w_count_next = r_count - CW'(1);
    end

    // The head can be the entry being written this cycle; bypass the memory in that case.
    w_bresp_next = 2'b00;
    if (w_count_next != '0) begin
      if (w_push && (r_wr_ptr == w_rd_ptr_next)) begin
        w_bresp_next = w_resp_enc;
      end else begin
        w_bresp_next = r_mem[w_rd_ptr_next];
      end
    end
  end

  always_ff @(posedge AXI_ACLK) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_resp_enc;
    end
  end

  always_ff @(posedge AXI_ACLK) begin
    if (AXI_ARESET) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_bvalid <= 1'b0;
      r_bresp  <= 2'b00;
      r_full   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      r_rd_ptr <= w_rd_ptr_next;
      r_count  <= w_count_next;
      r_bvalid <= (w_count_next != '0);
      r_bresp  <= w_bresp_next;
      r_full   <= (w_count_next == CW'(DEPTH));
      if (bus.WR_DONE && r_full) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign bus.AXI_BVALID = r_bvalid;
  assign bus.AXI_BRESP  = r_bresp;
  assign bus.WR_FULL    = r_full;
  assign bus.WR_OVF     = r_ovf;

`ifdef AXIL_WRESP_BREADY_TIMEOUT_EN
  localparam int unsigned WW = $clog2(MAXWAIT + 1);

  logic [WW-1:0] r_wait;
  logic [WW-1:0] w_wait_next;
  logic          r_timeout;

  always_comb begin
    w_wait_next = r_wait;
    if (!r_bvalid || w_pop) begin
      w_wait_next = '0;
    end else if (r_wait != WW'(MAXWAIT)) begin
      w_wait_next = r_wait + WW'(1);
    end
  end

  always_ff @(posedge AXI_ACLK) begin
    if (AXI_ARESET) begin
      r_wait    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_wait <= w_wait_next;
      if (w_wait_next == WW'(MAXWAIT)) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign bus.BREADY_TIMEOUT = r_timeout;
`else
  assign bus.BREADY_TIMEOUT = 1'b0;
`endif

endmodule
